// File: rtl/regs_sb.sv
// Parametrised register file with hardwired zero register, writeback bypass and a
// per-register pending scoreboard that stalls operand reads via valid/ready.
module regs_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic             req,
  input  logic             rst_n,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [AW-1:0]    rs1_in,
  input  logic [AW-1:0]    rs2_in,
  output logic [XLEN-1:0]  rs1_value_out,
  output logic [XLEN-1:0]  rs2_value_out,
  output logic             rd_rsp_valid,
  input  logic             claim_valid,
  input  logic [AW-1:0]    claim_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_value,
  output logic [NREGS-1:0] busy_out,
  output logic             claim_err
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic             rsp_valid_q;
  logic             claim_err_q, claim_err_d;
  logic             wb_en, claim_en, hz1, hz2, rd_accept;

  assign wb_en    = wb_valid && !(ZERO_REG && (wb_rd == '0));
  assign claim_en = claim_valid && !(ZERO_REG && (claim_rd == '0));

  // Hazards look only at pending state from cycle start; this cycle's claim is ignored
  always_comb begin
    hz1 = pend_q[rs1_in];
    hz2 = pend_q[rs2_in];
    if (BYPASS && wb_valid && (wb_rd == rs1_in)) hz1 = 1'b0;
    if (BYPASS && wb_valid && (wb_rd == rs2_in)) hz2 = 1'b0;
    if (ZERO_REG && (rs1_in == '0)) hz1 = 1'b0;
    if (ZERO_REG && (rs2_in == '0)) hz2 = 1'b0;
  end

  assign rd_req_ready = !hz1 && !hz2;
  assign rd_accept    = rd_req_valid && rd_req_ready;

  always_comb begin
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (rd_accept) begin
      if (ZERO_REG && (rs1_in == '0))                    rs1_d = '0;
      else if (BYPASS && wb_valid && (wb_rd == rs1_in))  rs1_d = wb_value;
      else                                               rs1_d = regs_q[rs1_in];
      if (ZERO_REG && (rs2_in == '0))                    rs2_d = '0;
      else if (BYPASS && wb_valid && (wb_rd == rs2_in))  rs2_d = wb_value;
      else                                               rs2_d = regs_q[rs2_in];
    end
  end

  // Claim is applied after writeback so a same-cycle pair leaves the register pending
  always_comb begin
    pend_d = pend_q;
    if (wb_en)    pend_d[wb_rd]    = 1'b0;
    if (claim_en) pend_d[claim_rd] = 1'b1;
    claim_err_d = claim_en && pend_q[claim_rd] && !(wb_en && (wb_rd == claim_rd));
  end

  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_rd] <= wb_value;
    end
  end

  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rsp_valid_q <= 1'b0;
      claim_err_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rsp_valid_q <= rd_accept;
      claim_err_q <= claim_err_d;
    end
  end

  assign rs1_value_out = rs1_q;
  assign rs2_value_out = rs2_q;
  assign rd_rsp_valid  = rsp_valid_q;
  assign busy_out      = pend_q;
  assign claim_err     = claim_err_q;

endmodule

// File: tb/tb_regs_sb.sv
// Bench for regs_sb: directed scenarios plus a randomized run against an array-based model.
module tb_regs_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             req = 1'b0;
  logic             rst_n;
  logic             rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [AW-1:0]    rs1_in, rs2_in, claim_rd, wb_rd;
  logic [XLEN-1:0]  rs1_value_out, rs2_value_out, wb_value;
  logic             claim_valid, wb_valid, claim_err;
  logic [NREGS-1:0] busy_out;

  logic             nb_rd_req_valid, nb_rd_req_ready, nb_rd_rsp_valid;
  logic [AW-1:0]    nb_rs1_in, nb_rs2_in, nb_claim_rd, nb_wb_rd;
  logic [XLEN-1:0]  nb_rs1_value_out, nb_rs2_value_out, nb_wb_value;
  logic             nb_claim_valid, nb_wb_valid, nb_claim_err;
  logic [NREGS-1:0] nb_busy_out;

  int errors = 0;
  int checks = 0;

  regs_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .req(req), .rst_n(rst_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rs1_value_out(rs1_value_out), .rs2_value_out(rs2_value_out),
    .rd_rsp_valid(rd_rsp_valid),
    .claim_valid(claim_valid), .claim_rd(claim_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value),
    .busy_out(busy_out), .claim_err(claim_err)
  );

  regs_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .req(req), .rst_n(rst_n),
    .rd_req_valid(nb_rd_req_valid), .rd_req_ready(nb_rd_req_ready),
    .rs1_in(nb_rs1_in), .rs2_in(nb_rs2_in),
    .rs1_value_out(nb_rs1_value_out), .rs2_value_out(nb_rs2_value_out),
    .rd_rsp_valid(nb_rd_rsp_valid),
    .claim_valid(nb_claim_valid), .claim_rd(nb_claim_rd),
    .wb_valid(nb_wb_valid), .wb_rd(nb_wb_rd), .wb_value(nb_wb_value),
    .busy_out(nb_busy_out), .claim_err(nb_claim_err)
  );

  always #5 req = ~req;

  task automatic tick();
    @(posedge req);
    #1;
  endtask

  task automatic idle();
    rd_req_valid = 1'b0; rs1_in = '0; rs2_in = '0;
    claim_valid = 1'b0; claim_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_value = '0;
    nb_rd_req_valid = 1'b0; nb_rs1_in = '0; nb_rs2_in = '0;
    nb_claim_valid = 1'b0; nb_claim_rd = '0;
    nb_wb_valid = 1'b0; nb_wb_rd = '0; nb_wb_value = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (busy_out !== '0) begin errors++;
      $display("FAIL reset_busy: got %h want 0", busy_out); end
    checks++; if (rd_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", rd_rsp_valid); end
    checks++; if (claim_err !== 1'b0) begin errors++;
      $display("FAIL reset_claim_err: got %b want 0", claim_err); end
    rst_n = 1'b1;
    rd_req_valid = 1'b1; rs1_in = 5'd5; rs2_in = 5'd0;
    #1;
    checks++; if (rd_req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_read_ready: got %b want 1", rd_req_ready); end
    tick();
    idle();
    checks++; if (rd_rsp_valid !== 1'b1 || rs1_value_out !== '0 || rs2_value_out !== '0) begin
      errors++;
      $display("FAIL reset_read: valid=%b rs1=%h rs2=%h want 1/0/0",
               rd_rsp_valid, rs1_value_out, rs2_value_out); end
    tick();
    checks++; if (rd_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL rsp_pulse_width: got %b want 0", rd_rsp_valid); end
  endtask

  task automatic test_write_read();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_value = 32'hDEADBEEF;
    tick();
    idle();
    rd_req_valid = 1'b1; rs1_in = 5'd3; rs2_in = 5'd3;
    tick();
    idle();
    checks++; if (rs1_value_out !== 32'hDEADBEEF || rs2_value_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_read_x3: rs1=%h rs2=%h want deadbeef", rs1_value_out, rs2_value_out); end
    wb_valid = 1'b1; wb_rd = 5'd0; wb_value = 32'h1234;
    tick();
    idle();
    rd_req_valid = 1'b1; rs1_in = 5'd0; rs2_in = 5'd3;
    tick();
    idle();
    checks++; if (rs1_value_out !== '0 || rs2_value_out !== 32'hDEADBEEF) begin errors++;
      $display("FAIL zero_reg_read: rs1=%h rs2=%h want 0/deadbeef",
               rs1_value_out, rs2_value_out); end
    tick();
    checks++; if (rs2_value_out !== 32'hDEADBEEF) begin errors++;
      $display("FAIL hold_value: got %h want deadbeef", rs2_value_out); end
  endtask

  task automatic test_stall_bypass();
    claim_valid = 1'b1; claim_rd = 5'd7;
    nb_claim_valid = 1'b1; nb_claim_rd = 5'd7;
    tick();
    idle();
    rd_req_valid = 1'b1; rs1_in = 5'd7; rs2_in = 5'd0;
    nb_rd_req_valid = 1'b1; nb_rs1_in = 5'd7; nb_rs2_in = 5'd0;
    #1;
    checks++; if (rd_req_ready !== 1'b0) begin errors++;
      $display("FAIL stall_ready: got %b want 0", rd_req_ready); end
    tick();
    checks++; if (busy_out[7] !== 1'b1 || rd_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL stall_busy: busy7=%b valid=%b want 1/0", busy_out[7], rd_rsp_valid); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_value = 32'hA5A5;
    nb_wb_valid = 1'b1; nb_wb_rd = 5'd7; nb_wb_value = 32'hA5A5;
    #1;
    checks++; if (rd_req_ready !== 1'b1) begin errors++;
      $display("FAIL bypass_ready: got %b want 1", rd_req_ready); end
    checks++; if (nb_rd_req_ready !== 1'b0) begin errors++;
      $display("FAIL nobypass_ready_same: got %b want 0", nb_rd_req_ready); end
    tick();
    checks++; if (rd_rsp_valid !== 1'b1 || rs1_value_out !== 32'hA5A5 || busy_out[7] !== 1'b0)
    begin errors++;
      $display("FAIL bypass_value: valid=%b rs1=%h busy7=%b want 1/a5a5/0",
               rd_rsp_valid, rs1_value_out, busy_out[7]); end
    checks++; if (nb_rd_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL nobypass_no_rsp: got %b want 0", nb_rd_rsp_valid); end
    idle();
    nb_rd_req_valid = 1'b1; nb_rs1_in = 5'd7;
    #1;
    checks++; if (nb_rd_req_ready !== 1'b1) begin errors++;
      $display("FAIL nobypass_ready_next: got %b want 1", nb_rd_req_ready); end
    tick();
    idle();
    checks++; if (nb_rd_rsp_valid !== 1'b1 || nb_rs1_value_out !== 32'hA5A5) begin errors++;
      $display("FAIL nobypass_value: valid=%b rs1=%h want 1/a5a5",
               nb_rd_rsp_valid, nb_rs1_value_out); end
  endtask

  task automatic test_read_claim_same();
    wb_valid = 1'b1; wb_rd = 5'd4; wb_value = 32'h11;
    tick();
    idle();
    rd_req_valid = 1'b1; rs1_in = 5'd4; rs2_in = 5'd3;
    claim_valid = 1'b1; claim_rd = 5'd4;
    #1;
    checks++; if (rd_req_ready !== 1'b1) begin errors++;
      $display("FAIL self_claim_ready: got %b want 1", rd_req_ready); end
    tick();
    idle();
    checks++; if (rs1_value_out !== 32'h11 || rs2_value_out !== 32'hDEADBEEF
                  || busy_out[4] !== 1'b1) begin errors++;
      $display("FAIL self_claim_value: rs1=%h rs2=%h busy4=%b want 11/deadbeef/1",
               rs1_value_out, rs2_value_out, busy_out[4]); end
    rd_req_valid = 1'b1; rs1_in = 5'd3; rs2_in = 5'd4;
    #1;
    checks++; if (rd_req_ready !== 1'b0) begin errors++;
      $display("FAIL rs2_stall: got %b want 0", rd_req_ready); end
    idle();
  endtask

  task automatic test_claim_err();
    claim_valid = 1'b1; claim_rd = 5'd9;
    tick();
    checks++; if (claim_err !== 1'b0 || busy_out[9] !== 1'b1) begin errors++;
      $display("FAIL first_claim: err=%b busy9=%b want 0/1", claim_err, busy_out[9]); end
    tick();
    idle();
    checks++; if (claim_err !== 1'b1) begin errors++;
      $display("FAIL double_claim_err: got %b want 1", claim_err); end
    tick();
    checks++; if (claim_err !== 1'b0 || busy_out[9] !== 1'b1) begin errors++;
      $display("FAIL claim_err_pulse: err=%b busy9=%b want 0/1", claim_err, busy_out[9]); end
    claim_valid = 1'b1; claim_rd = 5'd9;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_value = 32'h99;
    tick();
    idle();
    checks++; if (claim_err !== 1'b0 || busy_out[9] !== 1'b1) begin errors++;
      $display("FAIL claim_wb_same: err=%b busy9=%b want 0/1", claim_err, busy_out[9]); end
    claim_valid = 1'b1; claim_rd = 5'd0;
    tick();
    idle();
    checks++; if (busy_out[0] !== 1'b0 || claim_err !== 1'b0) begin errors++;
      $display("FAIL claim_x0: busy0=%b err=%b want 0/0", busy_out[0], claim_err); end
  endtask

  task automatic test_reset_mid();
    claim_valid = 1'b1; claim_rd = 5'd2;
    rd_req_valid = 1'b1; rs1_in = 5'd3; rs2_in = 5'd0;
    tick();
    idle();
    checks++; if (rd_rsp_valid !== 1'b1 || rs1_value_out !== 32'hDEADBEEF
                  || busy_out[2] !== 1'b1) begin errors++;
      $display("FAIL pre_reset: valid=%b rs1=%h busy2=%b want 1/deadbeef/1",
               rd_rsp_valid, rs1_value_out, busy_out[2]); end
    rd_req_valid = 1'b1; rs1_in = 5'd2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_rsp_valid !== 1'b0 || rs1_value_out !== '0 || busy_out !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b rs1=%h busy=%h want 0/0/0",
               rd_rsp_valid, rs1_value_out, busy_out); end
    tick();
    rst_n = 1'b1;
    rd_req_valid = 1'b1; rs1_in = 5'd2; rs2_in = 5'd3;
    #1;
    checks++; if (rd_req_ready !== 1'b1) begin errors++;
      $display("FAIL post_reset_ready: got %b want 1", rd_req_ready); end
    tick();
    idle();
    checks++; if (rd_rsp_valid !== 1'b1 || rs1_value_out !== '0 || rs2_value_out !== '0) begin
      errors++;
      $display("FAIL post_reset_read: valid=%b rs1=%h rs2=%h want 1/0/0",
               rd_rsp_valid, rs1_value_out, rs2_value_out); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_pend;
    logic [XLEN-1:0]  m_v1, m_v2;
    logic             hz1, hz2, exp_ready, acc, exp_err;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_pend = '0; m_v1 = '0; m_v2 = '0;
    for (int n = 0; n < 400; n++) begin
      rd_req_valid = ($urandom_range(0, 3) != 0);
      rs1_in = AW'($urandom_range(0, 7));
      rs2_in = AW'($urandom_range(0, 7));
      claim_valid = ($urandom_range(0, 3) == 0);
      claim_rd = AW'($urandom_range(0, 7));
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_rd = AW'($urandom_range(0, 7));
      wb_value = $urandom;
      #1;
      hz1 = (rs1_in != 0) && m_pend[rs1_in] && !(wb_valid && wb_rd == rs1_in);
      hz2 = (rs2_in != 0) && m_pend[rs2_in] && !(wb_valid && wb_rd == rs2_in);
      exp_ready = !hz1 && !hz2;
      checks++; if (rd_req_ready !== exp_ready) begin errors++;
        $display("FAIL rnd_ready[%0d]: got %b want %b", n, rd_req_ready, exp_ready); end
      acc = rd_req_valid && exp_ready;
      if (acc) begin
        m_v1 = (rs1_in == 0) ? '0 : (wb_valid && wb_rd == rs1_in) ? wb_value : m_regs[rs1_in];
        m_v2 = (rs2_in == 0) ? '0 : (wb_valid && wb_rd == rs2_in) ? wb_value : m_regs[rs2_in];
      end
      exp_err = claim_valid && (claim_rd != 0) && m_pend[claim_rd]
                && !(wb_valid && wb_rd == claim_rd);
      if (wb_valid && wb_rd != 0) begin
        m_regs[wb_rd] = wb_value;
        m_pend[wb_rd] = 1'b0;
      end
      if (claim_valid && claim_rd != 0) m_pend[claim_rd] = 1'b1;
      tick();
      checks++; if (rd_rsp_valid !== acc) begin errors++;
        $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", n, rd_rsp_valid, acc); end
      checks++; if (rs1_value_out !== m_v1 || rs2_value_out !== m_v2) begin errors++;
        $display("FAIL rnd_values[%0d]: got %h/%h want %h/%h",
                 n, rs1_value_out, rs2_value_out, m_v1, m_v2); end
      checks++; if (busy_out !== m_pend) begin errors++;
        $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy_out, m_pend); end
      checks++; if (claim_err !== exp_err) begin errors++;
        $display("FAIL rnd_claim_err[%0d]: got %b want %b", n, claim_err, exp_err); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall_bypass();
    test_read_claim_same();
    test_claim_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
